// File: rtl/static_axil_role_master.sv
// Static-region AXI4-Lite initiator driving the role's AXI-Lite slave port.
// One transaction in flight; a watchdog answers for a hung role, then drains it.
module static_axil_role_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  CLK_IN_250,
    input  logic                  AXI_RESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_W-1:0]     m_araddr,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    output logic [15:0]           to_count
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WD_W   = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_RESP, S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                b_pend_q, b_pend_d;
    logic                r_pend_q, r_pend_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                drain_q, drain_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [15:0]         to_count_q, to_count_d;

    logic accept;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic aw_left, w_left, ar_left, b_left, r_left;
    logic busy, done, timeout;

    assign accept  = (state_q == S_IDLE) & cmd_ready_q & cmd_valid;
    assign aw_hs   = awvalid_q & m_awready;
    assign w_hs    = wvalid_q & m_wready;
    assign ar_hs   = arvalid_q & m_arready;
    assign b_hs    = bready_q & m_bvalid;
    assign r_hs    = rready_q & m_rvalid;
    // Handshakes still owed after this cycle, whatever the state.
    assign aw_left = awvalid_q & ~aw_hs;
    assign w_left  = wvalid_q & ~w_hs;
    assign ar_left = arvalid_q & ~ar_hs;
    assign b_left  = b_pend_q & ~b_hs;
    assign r_left  = r_pend_q & ~r_hs;
    assign busy    = (state_q == S_WRITE) | (state_q == S_WRESP) |
                     (state_q == S_READ)  | (state_q == S_RDATA);
    assign done    = ((state_q == S_WRESP) & b_hs) |
                     ((state_q == S_RDATA) & r_hs);
    assign timeout = busy & (wd_q == WD_LAST) & ~done;

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK_IN_250) begin
        if (AXI_RESET) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            b_pend_q      <= 1'b0;
            r_pend_q      <= 1'b0;
            wd_q          <= '0;
            drain_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            to_count_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            b_pend_q      <= b_pend_d;
            r_pend_q      <= r_pend_d;
            wd_q          <= wd_d;
            drain_q       <= drain_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            to_count_q    <= to_count_d;
        end
    end

    // Next-state: transaction phases, watchdog exit, and drain of abandoned work.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = cmd_wr ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                if (timeout)                state_d = S_RESP;
                else if (!aw_left && !w_left) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (b_hs || timeout) state_d = S_RESP;
            end
            S_READ: begin
                if (timeout)       state_d = S_RESP;
                else if (!ar_left) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (r_hs || timeout) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = drain_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!aw_left && !w_left && !ar_left && !b_left && !r_left)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs: channel valids/readies, watchdog and response fields.
    always_comb begin
        cmd_ready_d   = (state_d == S_IDLE);
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = aw_left;
        wvalid_d      = w_left;
        arvalid_d     = ar_left;
        b_pend_d      = b_left;
        r_pend_d      = r_left;
        wd_d          = wd_q;
        drain_d       = drain_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        to_count_d    = to_count_q;

        if (accept) begin
            awaddr_d  = cmd_addr;
            araddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = cmd_wr;
            wvalid_d  = cmd_wr;
            arvalid_d = ~cmd_wr;
            b_pend_d  = cmd_wr;
            r_pend_d  = ~cmd_wr;
            wd_d      = '0;
            drain_d   = 1'b0;
        end else if (busy) begin
            wd_d = wd_q + WD_W'(1);
        end

        // A response is only owed once its address/data beats are through.
        bready_d = b_pend_d & ~awvalid_d & ~wvalid_d;
        rready_d = r_pend_d & ~arvalid_d;

        if (timeout) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            drain_d       = 1'b1;
            if (to_count_q != 16'hFFFF) to_count_d = to_count_q + 16'd1;
        end else if (done) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b0;
            if (state_q == S_RDATA) begin
                rsp_rdata_d = m_rdata;
                rsp_resp_d  = m_rresp;
            end else begin
                rsp_rdata_d = '0;
                rsp_resp_d  = m_bresp;
            end
        end else if (state_q == S_RESP && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (state_q == S_DRAIN && state_d == S_IDLE) drain_d = 1'b0;
    end

    assign cmd_ready   = cmd_ready_q;
    assign m_awvalid   = awvalid_q;
    assign m_awaddr    = awaddr_q;
    assign m_wvalid    = wvalid_q;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign m_bready    = bready_q;
    assign m_arvalid   = arvalid_q;
    assign m_araddr    = araddr_q;
    assign m_rready    = rready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign to_count    = to_count_q;

endmodule

// File: tb/tb_static_axil_role_master.sv
// Bench for static_axil_role_master: behavioural AXI-Lite slave, word-level
// reference memory, and a response scoreboard fed at command accept.
module tb_static_axil_role_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        AXI_RESET;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;
    logic [15:0] to_count;

    static_axil_role_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK_IN_250(clk), .AXI_RESET(AXI_RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_bresp(m_bresp), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_araddr(m_araddr), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .to_count(to_count)
    );

    always #2 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] s_mem[logic [31:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    int rise_cyc = 0;
    int rdy_mode = 0;
    int s_awd = 0, s_wd = 0, s_bd = 0, s_ard = 0, s_rd = 0;
    logic [1:0] s_resp = 2'b00;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s act=no_event exp=event_within_bound", nm);
    endtask

    // Reference memory: whole-word merge under a byte mask.
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[a] = (ref_rd(a) & ~m) | (d & m);
    endtask

    // Issue one command; expected response is queued at accept.
    task automatic send(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int awd, input int wdl, input int bd,
                        input int ard, input int rd, input logic [1:0] rs,
                        input bit exp_to, output int acc);
        exp_t e;
        int n;
        @(negedge clk);
        cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            bound_fail("cmd_accept");
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        s_awd = awd; s_wd = wdl; s_bd = bd; s_ard = ard; s_rd = rd;
        s_resp = rs;
        if (exp_to) begin
            e.rdata = 32'h0; e.resp = 2'b10; e.to = 1'b1;
        end else if (wr) begin
            ref_wr(a, d, s);
            e.rdata = 32'h0; e.resp = rs; e.to = 1'b0;
        end else begin
            e.rdata = ref_rd(a); e.resp = rs; e.to = 1'b0;
        end
        exp_q.push_back(e);
        acc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Response consumer and scoreboard monitor.
    initial begin
        exp_t e;
        logic prev_rv;
        prev_rv = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (AXI_RESET) begin
                rsp_ready = 1'b0;
            end else if (rdy_mode == 0) begin
                rsp_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                rsp_ready = 1'($urandom_range(0, 1));
            end else begin
                rsp_ready = 1'b0;
            end
            if (rsp_valid && !prev_rv) rise_cyc = cyc + 1;
            prev_rv = rsp_valid;
            if (!AXI_RESET && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp act=rsp exp=none");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                end
            end
        end
    end

    // Behavioural AXI-Lite slave plus handshake-rule monitor.
    initial begin
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit aw_got, w_got, b_pend, r_pend, prev_rst;
        bit p_aw, p_w, p_ar;
        logic [31:0] aw_a, w_d, tmp;
        logic [3:0] w_s;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; prev_rst = 1;
        p_aw = 0; p_w = 0; p_ar = 0; aw_a = 0; w_d = 0; w_s = 0;
        forever begin
            @(negedge clk);
            if (AXI_RESET) begin
                m_awready = 0; m_wready = 0; m_arready = 0;
                m_bvalid = 0; m_rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                p_aw = 0; p_w = 0; p_ar = 0;
                prev_rst = 1;
                continue;
            end
            if (b_pend) begin
                if (b_cnt >= s_bd) m_bvalid = 1; else b_cnt++;
            end else m_bvalid = 0;
            if (m_bvalid && m_bready) b_pend = 0;
            if (r_pend) begin
                if (r_cnt >= s_rd) m_rvalid = 1; else r_cnt++;
            end else m_rvalid = 0;
            if (m_rvalid && m_rready) r_pend = 0;
            if (m_awvalid) begin
                m_awready = (aw_cnt >= s_awd);
                if (m_awready) begin
                    aw_got = 1; aw_a = m_awaddr; aw_cnt = 0;
                end else aw_cnt++;
            end else m_awready = 0;
            if (m_wvalid) begin
                m_wready = (w_cnt >= s_wd);
                if (m_wready) begin
                    w_got = 1; w_d = m_wdata; w_s = m_wstrb; w_cnt = 0;
                end else w_cnt++;
            end else m_wready = 0;
            if (aw_got && w_got) begin
                tmp = s_mem.exists(aw_a) ? s_mem[aw_a] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) tmp[8*b +: 8] = w_d[8*b +: 8];
                s_mem[aw_a] = tmp;
                aw_got = 0; w_got = 0;
                b_pend = 1; b_cnt = 0; m_bresp = s_resp;
            end
            if (m_arvalid) begin
                m_arready = (ar_cnt >= s_ard);
                if (m_arready) begin
                    r_pend = 1; r_cnt = 0; ar_cnt = 0;
                    m_rdata = s_mem.exists(m_araddr) ? s_mem[m_araddr] : 32'h0;
                    m_rresp = s_resp;
                end else ar_cnt++;
            end else m_arready = 0;
            if (!prev_rst) begin
                if (p_aw && !m_awvalid) viol++;
                if (p_w && !m_wvalid) viol++;
                if (p_ar && !m_arvalid) viol++;
            end
            if (m_bready && (m_awvalid || m_wvalid)) viol++;
            if (m_rready && m_arvalid) viol++;
            p_aw = m_awvalid && !m_awready;
            p_w = m_wvalid && !m_wready;
            p_ar = m_arvalid && !m_arready;
            prev_rst = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        int acc, n, rdy_c;
        logic [31:0] hd;
        logic [1:0] hr;
        bit stable, blocked;
        AXI_RESET = 1; cmd_valid = 0; cmd_wr = 0;
        cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        s_mem[32'h20] = 32'h12345678;
        ref_mem[32'h20] = 32'h12345678;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_chan", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 64'(0));
        chk("rst_to_count", 64'(to_count), 64'(0));
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
        AXI_RESET = 0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // Zero-wait write, then read back.
        rdy_mode = 0;
        send(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, acc);
        n = 0;
        while (rise_cyc <= acc && n < 100) begin @(negedge clk); n++; end
        chk("wr_latency", 64'(rise_cyc - acc), 64'(3));
        send(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, acc);
        n = 0;
        while (rise_cyc <= acc && n < 100) begin @(negedge clk); n++; end
        chk("rd_latency", 64'(rise_cyc - acc), 64'(3));

        // Read with 5 wait cycles, response held off for 10 cycles.
        rdy_mode = 2;
        send(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b00, 0, acc);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (!rsp_valid) bound_fail("rd_rsp_valid");
        hd = rsp_rdata; hr = rsp_resp;
        stable = 1; blocked = 1;
        cmd_wr = 0; cmd_addr = 32'h20; cmd_valid = 1;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== hd || rsp_resp !== hr) stable = 0;
            if (cmd_ready) blocked = 0;
        end
        cmd_valid = 0;
        chk("rsp_hold_stable", 64'(stable), 64'(1));
        chk("cmd_blocked_in_resp", 64'(blocked), 64'(1));
        rdy_mode = 0;

        // AW 3 cycles ahead of W.
        send(1, 32'h30, 32'hA5A5_1234, 4'hF, 0, 3, 0, 0, 0, 2'b00, 0, acc);
        @(negedge clk);
        chk("aw_dropped", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b010));
        repeat (3) @(negedge clk);
        chk("bready_after_w", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b001));

        // Read that the role never answers in time.
        send(0, 32'h40, 32'h0, 4'h0, 0, 0, 0, 0, 38, 2'b00, 1, acc);
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        rdy_c = cyc;
        chk("to_count_one", 64'(to_count), 64'(1));
        chk("to_latency", 64'(rise_cyc - acc), 64'(TO + 1));
        chk("drain_release", 64'(rdy_c - acc), 64'(40));

        // Slave error passes through.
        send(1, 32'h50, 32'h0BAD_F00D, 4'h3, 1, 0, 2, 0, 0, 2'b10, 0, acc);
        send(0, 32'h50, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b00, 0, acc);

        // Reset in the read-data phase.
        send(0, 32'h60, 32'h0, 4'h0, 0, 0, 0, 0, 20, 2'b00, 0, acc);
        n = 0;
        while (!m_rready && n < 100) begin @(negedge clk); n++; end
        if (!m_rready) bound_fail("rdata_phase");
        AXI_RESET = 1;
        @(negedge clk);
        chk("midrst_chan", 64'({m_rready, rsp_valid, cmd_ready}), 64'(0));
        AXI_RESET = 0;
        exp_q.delete();
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        send(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 1, 2, 2'b00, 0, acc);

        // Random traffic with response back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(0, 1)),
                 32'h100 + 32'(4 * $urandom_range(0, 7)),
                 $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00, 0, acc);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        chk("axi_rules", 64'(viol), 64'(0));
        chk("final_to_count", 64'(to_count), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/static_axil_role_master.md
Name: static_axil_role_master

Overview:
- Static-region AXI4-Lite initiator that drives the role's AXI-Lite slave port (the S_AXI_LITE_FROM_STATIC side of role_NORTH).
- Converts a simple command/response stream from the host-side control logic into single AXI-Lite read or write transactions.
- Exactly one transaction outstanding at a time.
- A watchdog reports a hung role without blocking the command path indefinitely.

Parameters:
ADDR_W, 32, AXI-Lite address width
DATA_W, 32, AXI-Lite data width (32 or 64); STRB_W = DATA_W/8
TIMEOUT_CYC, 4096, cycles from issue to response before timeout is declared (>=4)

Ports:
CLK_IN_250  in  1  sole clock
AXI_RESET  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  STRB_W  write strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  AXI BRESP/RRESP, or 2'b10 on timeout
rsp_timeout  out  1  response produced by watchdog
m_awvalid/m_awready/m_awaddr  out/in/out  1/1/ADDR_W  write address channel
m_wvalid/m_wready/m_wdata/m_wstrb  out/in/out/out  1/1/DATA_W/STRB_W  write data channel
m_bvalid/m_bready/m_bresp  in/out/in  1/1/2  write response channel
m_arvalid/m_arready/m_araddr  out/in/out  1/1/ADDR_W  read address channel
m_rvalid/m_rready/m_rdata/m_rresp  in/out/in/in  1/1/DATA_W/2  read data channel
to_count  out  16  saturating count of timeouts since reset

Behaviour:
- Reset (AXI_RESET=1 at a rising edge): state IDLE. All m_*valid, m_bready, m_rready, rsp_valid, rsp_timeout, to_count and rsp data registers = 0. cmd_ready = 0 during reset.
- All outputs are registered. AWPROT/ARPROT are tied 3'b000 outside this block.
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, capture addr/wdata/wstrb.
  - Write: next cycle awvalid=wvalid=1, enter WRITE.
  - Read: arvalid=1, enter READ.
- WRITE: AW and W complete independently. Each valid drops the cycle after its own handshake. Once both have handshaken (possibly the same cycle), go to WRESP with bready=1.
- WRESP: on bvalid, latch bresp, drop bready, go to RESP.
- READ: on arready, drop arvalid, set rready=1, go to RDATA.
- RDATA: on rvalid, latch rdata/rresp, drop rready, go to RESP.
- Valids are never withdrawn before their handshake (AXI rule), including across a timeout.
- Watchdog:
  - Counter clears on command accept and increments every cycle in WRITE/WRESP/READ/RDATA.
  - When it reaches TIMEOUT_CYC-1 with the transaction incomplete: rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0. Saturating to_count++. Go to RESP with a drain flag set.
  - If the completing handshake and the timeout occur in the same cycle, the real response wins and there is no timeout.
- RESP: rsp_valid=1, fields held stable until rsp_ready.
  - On rsp_ready, go to DRAIN if the drain flag is set, else IDLE.
  - Back-to-back: at most one command accepted every 4 cycles. Minimum read latency cmd accept→rsp_valid = 3 cycles with zero-wait slave; minimum write latency is 3 cycles.
- DRAIN: complete any outstanding handshakes of the abandoned transaction, holding bready/rready=1 and discarding data. Return to IDLE when all are done; cmd_ready=0 throughout.
- Reset mid-transaction: all valids drop immediately and state returns to IDLE. The role is reset together with this block, so the lost handshake is acceptable.
- to_count saturates at 16'hFFFF.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF; zero-wait slave with bresp=0 → one AW+W beat, rsp_valid 3 cycles after accept, rsp_resp=0, rsp_timeout=0.
- Read 0x20 with slave returning 0x12345678, rresp=0 after 5 wait cycles → rsp_rdata=0x12345678, resp=0. Second command is not accepted until rsp_ready.
- AW accepted 3 cycles before W → awvalid drops after its own handshake, wvalid held; bready asserts only after the W handshake.
- Slave never responds to a read, TIMEOUT_CYC=16 → rsp_timeout=1, resp=2'b10, to_count=1. Late rvalid at cycle 40 is drained; cmd_ready returns 1 afterwards.
- rsp_ready held low 10 cycles → rsp fields stable and cmd_ready=0. Slave SLVERR (bresp=2'b10) is passed through with rsp_timeout=0.
- Assert AXI_RESET while in RDATA → next cycle rready=0, rsp_valid=0, cmd_ready=0. After reset deasserts, cmd_ready=1 and a new read completes normally.
